// File: rtl/regras_defuzzificador.sv
// Fuzzy rule consumer: min/max aggregation of rule firing strengths per output term,
// then singleton weighted-average defuzzification through a bit-serial signed divider.
//
// state    | meaning
// A_IDLE   | waiting for a Start code, rules and END ignored
// A_ACCUM  | frame open, rules max-aggregated into agg
// D_IDLE   | divider free
// D_RUN    | one restoring-division step per cycle
// D_OUT    | quotient sign-corrected and registered to out_val
// D_ZERO   | zero denominator, publishes 0 next cycle
module regras_defuzzificador #(
  parameter int MU_W  = 8,
  parameter int OUT_W = 8,
  parameter int S_NEG = -100,
  parameter int S_ZE  = 0,
  parameter int S_POS = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [5:0]        rule_code,
  input  logic [3*MU_W-1:0] mu_e,
  input  logic [3*MU_W-1:0] mu_de,
  output logic [OUT_W-1:0]  out_val,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic              code_err
);

  localparam int NW = MU_W + OUT_W + 2;
  localparam int DW = MU_W + 2;
  localparam int CW = $clog2(NW + 1);

  localparam logic [NW-1:0] S_NEG_W = NW'(S_NEG);
  localparam logic [NW-1:0] S_ZE_W  = NW'(S_ZE);
  localparam logic [NW-1:0] S_POS_W = NW'(S_POS);

  typedef enum logic {A_IDLE, A_ACCUM} acc_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_OUT, D_ZERO} div_state_t;

  acc_state_t              acc_state_q, acc_state_d;
  div_state_t              div_state_q, div_state_d;
  logic [2:0][MU_W-1:0]    agg_q, agg_d;
  logic [NW-1:0]           quo_q, quo_d;
  logic [DW-1:0]           rem_q, rem_d;
  logic [DW-1:0]           den_q, den_d;
  logic                    neg_q, neg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [OUT_W-1:0]        out_val_q, out_val_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    code_err_q, code_err_d;

  logic                    is_start, is_end, is_rule, rule_bad;
  logic [1:0]              idx_i, idx_j, cons;
  logic [2:0]              ij_sum;
  logic [MU_W-1:0]         mu_i, mu_j, w, agg_cur;
  logic [NW-1:0]           num, num_abs, quo_neg;
  logic [DW-1:0]           den;
  logic [DW:0]             shifted;
  logic [DW+1:0]           diff;
  logic                    div_busy;

  // Weight times signed singleton; weights are unsigned so they are zero-extended.
  function automatic logic [NW-1:0] wprod(input logic [MU_W-1:0] wt, input logic [NW-1:0] s);
    logic signed [NW-1:0] ws;
    logic signed [NW-1:0] ss;
    ws = $signed({{(NW-MU_W){1'b0}}, wt});
    ss = $signed(s);
    return NW'(ws * ss);
  endfunction

  always_comb begin
    is_start = (rule_code == 6'b010000);
    is_end   = (rule_code == 6'b100000);
    is_rule  = (rule_code[5:4] == 2'b00);
    idx_i    = rule_code[3:2];
    idx_j    = rule_code[1:0];
    rule_bad = (idx_i == 2'd3) || (idx_j == 2'd3);
    case (idx_i)
      2'd0:    mu_i = mu_e[0 +: MU_W];
      2'd1:    mu_i = mu_e[MU_W +: MU_W];
      default: mu_i = mu_e[2*MU_W +: MU_W];
    endcase
    case (idx_j)
      2'd0:    mu_j = mu_de[0 +: MU_W];
      2'd1:    mu_j = mu_de[MU_W +: MU_W];
      default: mu_j = mu_de[2*MU_W +: MU_W];
    endcase
    w      = (mu_i < mu_j) ? mu_i : mu_j;
    ij_sum = {1'b0, idx_i} + {1'b0, idx_j};
    cons   = (ij_sum < 3'd2) ? 2'd0 : ((ij_sum == 3'd2) ? 2'd1 : 2'd2);
    case (cons)
      2'd0:    agg_cur = agg_q[0];
      2'd1:    agg_cur = agg_q[1];
      default: agg_cur = agg_q[2];
    endcase
    num     = wprod(agg_q[0], S_NEG_W) + wprod(agg_q[1], S_ZE_W) + wprod(agg_q[2], S_POS_W);
    num_abs = num[NW-1] ? (~num + NW'(1)) : num;
    den     = {2'b00, agg_q[0]} + {2'b00, agg_q[1]} + {2'b00, agg_q[2]};
    shifted = {rem_q, quo_q[NW-1]};
    diff    = {1'b0, shifted} - {2'b00, den_q};
    quo_neg = ~quo_q + NW'(1);
    div_busy = (div_state_q == D_RUN) || (div_state_q == D_OUT);
  end

  always_comb begin
    acc_state_d = acc_state_q;
    div_state_d = div_state_q;
    agg_d       = agg_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    den_d       = den_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    out_val_d   = out_val_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    code_err_d  = code_err_q;

    case (div_state_q)
      D_RUN: begin
        if (!diff[DW+1]) begin
          rem_d = diff[DW-1:0];
          quo_d = {quo_q[NW-2:0], 1'b1};
        end else begin
          rem_d = shifted[DW-1:0];
          quo_d = {quo_q[NW-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) div_state_d = D_OUT;
      end
      D_OUT: begin
        out_val_d   = neg_q ? quo_neg[OUT_W-1:0] : quo_q[OUT_W-1:0];
        out_valid_d = 1'b1;
        div_state_d = D_IDLE;
      end
      D_ZERO: begin
        out_val_d   = '0;
        out_valid_d = 1'b1;
        div_state_d = D_IDLE;
      end
      default: ;
    endcase

    // The accumulator only moves on qualified codes; the divider above runs regardless.
    if (en) begin
      case (acc_state_q)
        A_IDLE: begin
          if (is_start) begin
            agg_d       = '0;
            acc_state_d = A_ACCUM;
          end
        end
        default: begin
          if (is_start) begin
            agg_d = '0;
          end else if (is_end) begin
            acc_state_d = A_IDLE;
            if (div_busy) begin
              overrun_d = 1'b1;
            end else if (den == '0) begin
              div_state_d = D_ZERO;
            end else begin
              div_state_d = D_RUN;
              quo_d       = num_abs;
              rem_d       = '0;
              den_d       = den;
              neg_d       = num[NW-1];
              cnt_d       = CW'(NW);
            end
          end else if (is_rule) begin
            if (rule_bad) begin
              code_err_d = 1'b1;
            end else if (w > agg_cur) begin
              case (cons)
                2'd0:    agg_d[0] = w;
                2'd1:    agg_d[1] = w;
                default: agg_d[2] = w;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_state_q <= A_IDLE;
      div_state_q <= D_IDLE;
      agg_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      den_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      acc_state_q <= acc_state_d;
      div_state_q <= div_state_d;
      agg_q       <= agg_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      den_q       <= den_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      code_err_q  <= code_err_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_valid = out_valid_q;
  assign busy      = div_busy;
  assign overrun   = overrun_q;
  assign code_err  = code_err_q;

endmodule

// File: tb/tb_regras_defuzzificador.sv
// Directed checks of the rule aggregator / defuzzifier against hand-computed results.
module tb_regras_defuzzificador;

  localparam logic [5:0] C_START = 6'b010000;
  localparam logic [5:0] C_END   = 6'b100000;
  localparam int         DIV_LAT = 19;

  logic        clk;
  logic        rst;
  logic        en;
  logic [5:0]  rule_code;
  logic [23:0] mu_e;
  logic [23:0] mu_de;
  logic [7:0]  out_val;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        code_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int pulses;

  regras_defuzzificador dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rule_code (rule_code),
    .mu_e      (mu_e),
    .mu_de     (mu_de),
    .out_val   (out_val),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .code_err  (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mu(input logic [7:0] en_, input logic [7:0] ez, input logic [7:0] ep,
                        input logic [7:0] dn, input logic [7:0] dz, input logic [7:0] dp);
    mu_e  = {ep, ez, en_};
    mu_de = {dp, dz, dn};
  endtask

  task automatic send(input logic [5:0] c, input logic qual);
    rule_code = c;
    en        = qual;
    @(posedge clk);
    #1;
    en        = 1'b0;
    rule_code = 6'b000000;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic count_pulses(input int cycles, output int p);
    p = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) p++;
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    rule_code = 6'b000000;
    mu_e = '0;
    mu_de = '0;
    @(posedge clk);
    #1;
    chk("rst_out_val", $signed(out_val), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_code_err", code_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Empty frame: zero denominator, result one cycle after END
    send(C_START, 1'b1);
    send(C_END, 1'b1);
    chk("empty_busy", busy, 0);
    wait_valid(cyc);
    chk("empty_valid", out_valid, 1);
    chk("empty_lat", cyc, 1);
    chk("empty_val", $signed(out_val), 0);
    @(posedge clk);
    #1;
    chk("empty_pulse_end", out_valid, 0);

    // (Z,Z) w=100 -> ZE only, quotient 0 after full division
    set_mu(8'd0, 8'd200, 8'd0, 8'd0, 8'd100, 8'd0);
    send(C_START, 1'b1);
    send(6'b000101, 1'b1);
    send(C_END, 1'b1);
    chk("ze_busy", busy, 1);
    wait_valid(cyc);
    chk("ze_valid", out_valid, 1);
    chk("ze_lat", cyc, DIV_LAT);
    chk("ze_val", $signed(out_val), 0);
    chk("ze_busy_fall", busy, 0);

    // NEG w=128, POS w=64 -> -6400/192 = -33 truncated
    set_mu(8'd255, 8'd0, 8'd64, 8'd128, 8'd0, 8'd200);
    send(C_START, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b001010, 1'b1);
    send(C_END, 1'b1);
    wait_valid(cyc);
    chk("mix_valid", out_valid, 1);
    chk("mix_lat", cyc, DIV_LAT);
    chk("mix_val", $signed(out_val), -33);
    @(posedge clk);
    #1;
    chk("mix_pulse_end", out_valid, 0);
    chk("mix_hold", $signed(out_val), -33);

    // Two NEG rules w=50 and w=90 -> -100
    set_mu(8'd255, 8'd90, 8'd0, 8'd200, 8'd50, 8'd0);
    send(C_START, 1'b1);
    send(6'b000001, 1'b1);
    send(6'b000100, 1'b1);
    send(C_END, 1'b1);
    wait_valid(cyc);
    chk("neg2_val", $signed(out_val), -100);

    // Same plus POS w=90: max gives 0, a sum would give -21
    set_mu(8'd255, 8'd90, 8'd90, 8'd200, 8'd50, 8'd90);
    send(C_START, 1'b1);
    send(6'b000001, 1'b1);
    send(6'b000100, 1'b1);
    send(6'b001010, 1'b1);
    send(C_END, 1'b1);
    wait_valid(cyc);
    chk("maxagg_val", $signed(out_val), 0);

    // Illegal code and unqualified code must leave agg untouched
    set_mu(8'd60, 8'd0, 8'd250, 8'd60, 8'd0, 8'd250);
    send(C_START, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b001010, 1'b0);
    chk("pre_code_err", code_err, 0);
    send(6'b001100, 1'b1);
    chk("code_err_set", code_err, 1);
    send(C_END, 1'b1);
    wait_valid(cyc);
    chk("illegal_val", $signed(out_val), -100);
    chk("code_err_sticky", code_err, 1);

    // Second END during division is dropped
    set_mu(8'd255, 8'd0, 8'd64, 8'd128, 8'd0, 8'd200);
    send(C_START, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b001010, 1'b1);
    send(C_END, 1'b1);
    send(C_START, 1'b1);
    send(6'b001010, 1'b1);
    chk("ovr_pre", overrun, 0);
    send(C_END, 1'b1);
    chk("ovr_set", overrun, 1);
    chk("ovr_busy", busy, 1);
    wait_valid(cyc);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_first_val", $signed(out_val), -33);
    count_pulses(25, pulses);
    chk("ovr_no_second", pulses, 0);
    chk("ovr_hold", $signed(out_val), -33);

    // Reset mid-division clears everything and suppresses the pending result
    set_mu(8'd128, 8'd0, 8'd0, 8'd128, 8'd0, 8'd0);
    send(C_START, 1'b1);
    send(6'b000000, 1'b1);
    send(C_END, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_out_val", $signed(out_val), 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_code_err", code_err, 0);
    chk("mrst_valid", out_valid, 0);
    rst = 1'b0;
    count_pulses(30, pulses);
    chk("mrst_no_pulse", pulses, 0);

    // Start mid-frame restarts aggregation: only POS w=50 survives -> 100
    set_mu(8'd200, 8'd0, 8'd50, 8'd200, 8'd0, 8'd50);
    send(C_START, 1'b1);
    send(6'b000000, 1'b1);
    send(C_START, 1'b1);
    send(6'b001010, 1'b1);
    send(C_END, 1'b1);
    wait_valid(cyc);
    chk("restart_valid", out_valid, 1);
    chk("restart_val", $signed(out_val), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
